// File: rtl/ddrctl1_requester_if.sv
// ddrctl1_requester_if: client request/response and DdrCtl1 instruction-port bundle.
// Rev 1.0 -- slave is the requester's view, master is the client/controller side.
`default_nettype none

interface ddrctl1_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        err;
  logic [11:0] inst;
  logic        inst_en;
  logic [31:0] ctl_page;
  logic        ctl_ready;
  logic        ctl_locked;

  modport slave (
    input  req_valid, req_write, req_addr, req_data, ctl_page, ctl_ready, ctl_locked,
    output req_ready, rsp_valid, rsp_data, err, inst, inst_en
  );

  modport master (
    output req_valid, req_write, req_addr, req_data, ctl_page, ctl_ready, ctl_locked,
    input  req_ready, rsp_valid, rsp_data, err, inst, inst_en
  );
endinterface

`default_nettype wire

// File: rtl/ddrctl1_requester.sv
// ddrctl1_requester: serialises client word read/write requests into DdrCtl1 instructions.
// Rev 1.0 -- optional ADDR_CACHE_EN skips LA0..LA3 when the page address is unchanged.
`default_nettype none

`ifndef DdrCtl1_NOP
`define DdrCtl1_NOP 4'h0
`define DdrCtl1_LCK 4'h1
`define DdrCtl1_ULK 4'h2
`define DdrCtl1_LA0 4'h3
`define DdrCtl1_LA1 4'h4
`define DdrCtl1_LA2 4'h5
`define DdrCtl1_LA3 4'h6
`define DdrCtl1_LD0 4'h7
`define DdrCtl1_LD1 4'h8
`define DdrCtl1_LD2 4'h9
`define DdrCtl1_LD3 4'hA
`define DdrCtl1_WRP 4'hB
`define DdrCtl1_RDP 4'hC
`endif

module ddrctl1_requester #(
  parameter int TIMEOUT   = 1023,
  parameter int TIMEOUT_W = 10
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ddrctl1_requester_if.slave bus
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LCK     = 4'd1;
  localparam logic [3:0] S_LA0     = 4'd2;
  localparam logic [3:0] S_LA1     = 4'd3;
  localparam logic [3:0] S_LA2     = 4'd4;
  localparam logic [3:0] S_LA3     = 4'd5;
  localparam logic [3:0] S_LD0     = 4'd6;
  localparam logic [3:0] S_LD1     = 4'd7;
  localparam logic [3:0] S_LD2     = 4'd8;
  localparam logic [3:0] S_LD3     = 4'd9;
  localparam logic [3:0] S_ULK     = 4'd10;
  localparam logic [3:0] S_ISSUE   = 4'd11;
  localparam logic [3:0] S_WAIT_LO = 4'd12;
  localparam logic [3:0] S_WAIT_HI = 4'd13;
  localparam logic [3:0] S_DONE    = 4'd14;

  localparam logic [TIMEOUT_W-1:0] c_TIMEOUT = TIMEOUT_W'(TIMEOUT);

  logic [3:0]           r_state;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_write;
  logic [31:0]          r_addr;
  logic [31:0]          r_data;
  logic                 r_skip_la;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_data;
  logic                 r_err;
  logic [11:0]          r_inst;
  logic                 r_inst_en;

  logic [3:0]           w_next_state;
  logic                 w_accept;
  logic                 w_skip_la;
  logic                 w_cnt_hit;
  logic                 w_timeout;
  logic                 w_capture;
  logic                 w_in_wait;
  logic [3:0]           w_op;
  logic [7:0]           w_imm;
  logic                 w_inst_en_nxt;
  logic                 w_req_ready_nxt;
  logic                 w_rsp_valid_nxt;
  logic [31:0]          w_rsp_data_nxt;
  logic                 w_err_nxt;

  assign w_accept  = (r_state == S_IDLE) & r_req_ready & bus.req_valid;
  assign w_cnt_hit = (r_cnt == c_TIMEOUT);
  assign w_in_wait = (r_state == S_ISSUE) | (r_state == S_WAIT_LO) | (r_state == S_WAIT_HI);

`ifdef ADDR_CACHE_EN
  logic        r_cache_vld;
  logic [31:0] r_cache_addr;

  assign w_skip_la = r_cache_vld & (bus.req_addr == r_cache_addr);

  // The address is considered loaded once LA3 has been emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_vld  <= 1'b0;
      r_cache_addr <= 32'h0;
    end else if (w_timeout) begin
      r_cache_vld  <= 1'b0;
    end else if (r_state == S_LA3) begin
      r_cache_vld  <= 1'b1;
      r_cache_addr <= r_addr;
    end
  end
`else
  assign w_skip_la = 1'b0;
`endif

  // State register and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state)
        r_cnt <= '0;
      else if (w_in_wait)
        r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_LCK;
      S_LCK:     w_next_state = !r_skip_la ? S_LA0 : (r_write ? S_LD0 : S_ULK);
      S_LA0:     w_next_state = S_LA1;
      S_LA1:     w_next_state = S_LA2;
      S_LA2:     w_next_state = S_LA3;
      S_LA3:     w_next_state = r_write ? S_LD0 : S_ULK;
      S_LD0:     w_next_state = S_LD1;
      S_LD1:     w_next_state = S_LD2;
      S_LD2:     w_next_state = S_LD3;
      S_LD3:     w_next_state = S_ULK;
      S_ULK:     w_next_state = S_ISSUE;
      // r_inst_en here means WRP/RDP is on the bus this cycle.
      S_ISSUE: begin
        if (r_inst_en) begin
          w_next_state = S_WAIT_LO;
        end else if (w_cnt_hit) begin
          w_next_state = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.ctl_ready) begin
          w_next_state = S_WAIT_HI;
        end else if (w_cnt_hit) begin
          w_next_state = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (bus.ctl_ready) begin
          w_next_state = S_DONE;
          w_capture    = ~r_write;
        end else if (w_cnt_hit) begin
          w_next_state = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output logic: next-cycle values of the registered outputs
  always_comb begin
    w_op          = `DdrCtl1_NOP;
    w_imm         = 8'h00;
    w_inst_en_nxt = 1'b0;
    case (w_next_state)
      S_LCK:   begin w_op = `DdrCtl1_LCK; w_inst_en_nxt = 1'b1; end
      S_LA0:   begin w_op = `DdrCtl1_LA0; w_imm = r_addr[7:0];   w_inst_en_nxt = 1'b1; end
      S_LA1:   begin w_op = `DdrCtl1_LA1; w_imm = r_addr[15:8];  w_inst_en_nxt = 1'b1; end
      S_LA2:   begin w_op = `DdrCtl1_LA2; w_imm = r_addr[23:16]; w_inst_en_nxt = 1'b1; end
      S_LA3:   begin w_op = `DdrCtl1_LA3; w_imm = r_addr[31:24]; w_inst_en_nxt = 1'b1; end
      S_LD0:   begin w_op = `DdrCtl1_LD0; w_imm = r_data[7:0];   w_inst_en_nxt = 1'b1; end
      S_LD1:   begin w_op = `DdrCtl1_LD1; w_imm = r_data[15:8];  w_inst_en_nxt = 1'b1; end
      S_LD2:   begin w_op = `DdrCtl1_LD2; w_imm = r_data[23:16]; w_inst_en_nxt = 1'b1; end
      S_LD3:   begin w_op = `DdrCtl1_LD3; w_imm = r_data[31:24]; w_inst_en_nxt = 1'b1; end
      S_ULK:   begin w_op = `DdrCtl1_ULK; w_inst_en_nxt = 1'b1; end
      S_ISSUE: begin
        if (bus.ctl_ready) begin
          w_op          = r_write ? `DdrCtl1_WRP : `DdrCtl1_RDP;
          w_inst_en_nxt = 1'b1;
        end
      end
      default: ;
    endcase
    w_req_ready_nxt = (w_next_state == S_IDLE) & bus.ctl_ready;
    w_rsp_valid_nxt = (w_next_state == S_DONE);
    w_rsp_data_nxt  = w_capture ? bus.ctl_page : r_rsp_data;
    w_err_nxt       = r_err | w_timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_addr      <= 32'h0;
      r_data      <= 32'h0;
      r_skip_la   <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_err       <= 1'b0;
      r_inst      <= {`DdrCtl1_NOP, 8'h00};
      r_inst_en   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write   <= bus.req_write;
        r_addr    <= bus.req_addr;
        r_data    <= bus.req_data;
        r_skip_la <= w_skip_la;
      end
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_err       <= w_err_nxt;
      r_inst      <= {w_op, w_imm};
      r_inst_en   <= w_inst_en_nxt;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.err       = r_err;
  assign bus.inst      = r_inst;
  assign bus.inst_en   = r_inst_en;

endmodule

`default_nettype wire

// File: tb/tb_ddrctl1_requester.sv
// tb_ddrctl1_requester: random and directed requests against a behavioural DdrCtl1 model.
// Rev 1.0 -- expectations follow ADDR_CACHE_EN when it is defined for the build.
`default_nettype none

module tb_ddrctl1_requester;

  localparam int TIMEOUT   = 1023;
  localparam int TIMEOUT_W = 10;
  localparam int INIT_CYC  = 100;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LCK = 4'h1, OP_ULK = 4'h2;
  localparam logic [3:0] OP_LA0 = 4'h3, OP_LA1 = 4'h4, OP_LA2 = 4'h5, OP_LA3 = 4'h6;
  localparam logic [3:0] OP_LD0 = 4'h7, OP_LD1 = 4'h8, OP_LD2 = 4'h9, OP_LD3 = 4'hA;
  localparam logic [3:0] OP_WRP = 4'hB, OP_RDP = 4'hC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddrctl1_requester_if bus();

  ddrctl1_requester #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] blank_page(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // ---------------- DdrCtl1 behavioural model ----------------
  logic [31:0] m_mem [logic [31:0]];
  logic [31:0] m_addr, m_data;
  int          m_init, m_busy;
  logic        m_pend_rd;
  logic        m_hold = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ctl_ready  <= 1'b0;
      bus.ctl_locked <= 1'b0;
      bus.ctl_page   <= 32'h0;
      m_init <= 0; m_busy <= 0; m_pend_rd <= 1'b0;
      m_addr <= 32'h0; m_data <= 32'h0;
    end else if (m_init < INIT_CYC) begin
      m_init <= m_init + 1;
      if (m_init == INIT_CYC - 1) bus.ctl_ready <= 1'b1;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        bus.ctl_ready <= 1'b1;
        if (m_pend_rd)
          bus.ctl_page <= m_mem.exists(m_addr) ? m_mem[m_addr] : blank_page(m_addr);
        m_pend_rd <= 1'b0;
      end
    end else if (bus.inst_en) begin
      case (bus.inst[11:8])
        OP_LCK: bus.ctl_locked <= 1'b1;
        OP_ULK: bus.ctl_locked <= 1'b0;
        OP_LA0: m_addr[7:0]   <= bus.inst[7:0];
        OP_LA1: m_addr[15:8]  <= bus.inst[7:0];
        OP_LA2: m_addr[23:16] <= bus.inst[7:0];
        OP_LA3: m_addr[31:24] <= bus.inst[7:0];
        OP_LD0: m_data[7:0]   <= bus.inst[7:0];
        OP_LD1: m_data[15:8]  <= bus.inst[7:0];
        OP_LD2: m_data[23:16] <= bus.inst[7:0];
        OP_LD3: m_data[31:24] <= bus.inst[7:0];
        OP_WRP, OP_RDP: if (!m_hold) begin
          if (bus.inst[11:8] == OP_WRP) m_mem[m_addr] = m_data;
          else                          m_pend_rd <= 1'b1;
          bus.ctl_ready <= 1'b0;
          m_busy <= int'($urandom_range(1, 6));
        end
        default: ;
      endcase
    end
  end

  // ---------------- Instruction monitor ----------------
  logic [11:0] obs_q [$];
  int          lock_faults = 0, nop_faults = 0;
  logic        in_lock = 1'b0;
  time         issue_t = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_lock = 1'b0;
    end else if (bus.inst_en) begin
      obs_q.push_back(bus.inst);
      if (in_lock && !bus.ctl_locked) lock_faults++;
      if (bus.inst[11:8] == OP_LCK) in_lock = 1'b1;
      if (bus.inst[11:8] == OP_ULK) in_lock = 1'b0;
      if (bus.inst[11:8] == OP_WRP || bus.inst[11:8] == OP_RDP) issue_t = $time;
    end else if (bus.inst[11:8] != OP_NOP) begin
      nop_faults++;
    end
  end

  // ---------------- Reference state ----------------
  logic [31:0] sb_mem [logic [31:0]];
  logic        sb_err = 1'b0;
  logic [31:0] sb_rsp = 32'h0;
  logic        cache_vld = 1'b0;
  logic [31:0] cache_addr = 32'h0;

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 400) begin @(negedge clk); n++; end
    check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit expect_to, input string tag);
    logic [11:0] exp_q [$];
    logic [31:0] got_data;
    logic        got_err;
    logic [3:0]  op;
    bit          skip = 1'b0;
    int          n;
    longint      dly;
`ifdef ADDR_CACHE_EN
    skip = cache_vld && (cache_addr == a);
`endif
    exp_q.push_back({OP_LCK, 8'h00});
    if (!skip) for (int i = 0; i < 4; i++) exp_q.push_back({4'(OP_LA0 + i), a[i*8 +: 8]});
    if (w)     for (int i = 0; i < 4; i++) exp_q.push_back({4'(OP_LD0 + i), d[i*8 +: 8]});
    exp_q.push_back({OP_ULK, 8'h00});
    exp_q.push_back({w ? OP_WRP : OP_RDP, 8'h00});

    @(negedge clk);
    obs_q.delete();
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_data = d;
    wait_ready(tag);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 4000) begin @(negedge clk); n++; end
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    got_data = bus.rsp_data;
    got_err  = bus.err;
    dly      = longint'(($time - issue_t) / 10);

    if (expect_to) begin
      sb_err    = 1'b1;
      cache_vld = 1'b0;
    end else begin
      if (w) sb_mem[a] = d;
      else   sb_rsp = sb_mem.exists(a) ? sb_mem[a] : blank_page(a);
      if (!skip) begin cache_vld = 1'b1; cache_addr = a; end
    end

    check_eq({tag, "_inst_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      op = exp_q[i][11:8];
      if (op >= OP_LA0 && op <= OP_LD3)
        check_eq($sformatf("%s_inst%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      else
        check_eq($sformatf("%s_op%0d", tag, i), 32'(obs_q[i][11:8]), 32'(op));
    end
    check_eq({tag, "_rsp_data"}, got_data, sb_rsp);
    check_eq({tag, "_err"}, 32'(got_err), 32'(sb_err));
    if (expect_to)
      check_eq({tag, "_to_window"}, 32'(dly >= TIMEOUT && dly <= TIMEOUT + 3), 32'd1);
    @(negedge clk);
    check_eq({tag, "_rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  logic [31:0] pool [6];

  initial begin
    int   n, bad;
    logic w;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0; bus.req_data = 32'h0;

    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data",  bus.rsp_data, 32'h0);
    check_eq("rst_err",       32'(bus.err), 32'd0);
    check_eq("rst_inst_en",   32'(bus.inst_en), 32'd0);
    check_eq("rst_inst",      32'(bus.inst), 32'({OP_NOP, 8'h00}));
    rst_n = 1'b1;

    // DDR init period: nothing may be accepted or emitted while ctl_ready is low
    n = 0; bad = 0;
    while (!bus.ctl_ready && n < 300) begin
      @(negedge clk); n++;
      if (!bus.ctl_ready && (bus.req_ready || bus.inst_en)) bad++;
    end
    check_eq("init_quiet", 32'(bad), 32'd0);
    check_eq("init_lag_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check_eq("init_req_ready", 32'(bus.req_ready), 32'd1);

    do_txn(1'b1, 32'h002B_3F12, 32'hDDCC_BBAA, 1'b0, "wr0");
    do_txn(1'b0, 32'h002B_3F12, 32'h0,         1'b0, "rd0");
    check_eq("rd0_value", sb_rsp, 32'hDDCC_BBAA);
    do_txn(1'b1, 32'h012B_3F12, $urandom,      1'b0, "wr1");
    do_txn(1'b0, 32'h012B_3F12, 32'h0,         1'b0, "rd1");

    for (int i = 0; i < 6; i++) pool[i] = $urandom;
    for (int t = 0; t < 30; t++) begin
      w = 1'($urandom_range(0, 1));
      do_txn(w, pool[$urandom_range(0, 5)], $urandom, 1'b0, $sformatf("rnd%0d", t));
    end

    // Controller never drops ready after WRP
    m_hold = 1'b1;
    do_txn(1'b1, pool[0], 32'h1234_5678, 1'b1, "to");
    m_hold = 1'b0;
    do_txn(1'b1, pool[1], 32'hCAFE_0001, 1'b0, "post_to_wr");
    do_txn(1'b0, pool[1], 32'h0,         1'b0, "post_to_rd");

    // Abort a write mid-stream with reset
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = 32'h0BAD_F00D; bus.req_data = 32'h5566_7788;
    wait_ready("abort");
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!(bus.inst_en && bus.inst[11:8] == OP_LD2) && n < 50) begin @(negedge clk); n++; end
    check_eq("abort_saw_ld2", 32'(bus.inst[11:8]), 32'(OP_LD2));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_inst_en",   32'(bus.inst_en), 32'd0);
    check_eq("abort_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("abort_err",       32'(bus.err), 32'd0);
    sb_err = 1'b0; sb_rsp = 32'h0; cache_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("rearm");
    do_txn(1'b1, 32'h0BAD_F00D, 32'h99AA_BBCC, 1'b0, "rst_wr");
    do_txn(1'b0, 32'h0BAD_F00D, 32'h0,         1'b0, "rst_rd");

    check_eq("lock_faults", 32'(lock_faults), 32'd0);
    check_eq("nop_faults",  32'(nop_faults), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
